// File: rtl/ccsds123_res_axis_out.sv
// AXI4-Stream master adapter for the CCSDS-123 non-stallable residual stream:
// FWFT FIFO, image-framed tlast, sticky overflow. Optional CCSDS123_RES_AXIS_OUT_HWM_EN adds max_level.
module ccsds123_res_axis_out #(
  parameter int D     = 16,
  parameter int NX    = 4,
  parameter int NY    = 4,
  parameter int NZ    = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [D-1:0]             res,
  input  logic                     res_valid,
  output logic [D-1:0]             m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef CCSDS123_RES_AXIS_OUT_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]   max_level
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int TOTAL = NX * NY * NZ;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [D:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [CW-1:0] cnt_r;
  logic          ovf_r;

  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          full_s;
  logic          last_s;
  logic [LW-1:0] level_nxt_s;
  logic [D:0]    head_s;

  // Handshake decode: a pop frees a slot in the same cycle, so full+pop still accepts the write.
  always_comb begin
    full_s = (level_r == LW'(DEPTH));
    pop_s  = (level_r != {LW{1'b0}}) && m_axis_tready;
    if (res_valid) begin
      push_s = !full_s || pop_s;
      drop_s = full_s && !pop_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    last_s = (cnt_r == CW'(TOTAL - 1));
  end

  // Occupancy update.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage array; cleared on reset so the head entry is never X.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(D + 1){1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {last_s, res};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
    end
  end

  // Image sample counter advances on drops too so framing survives an overflow.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r <= {CW{1'b0}};
    end else if (res_valid) begin
      if (last_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end
  end

`ifdef CCSDS123_RES_AXIS_OUT_HWM_EN
  logic [LW-1:0] max_level_r;

  // High-water mark tracks the occupancy about to be registered.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      max_level_r <= {LW{1'b0}};
    end else if (level_nxt_s > max_level_r) begin
      max_level_r <= level_nxt_s;
    end
  end

  assign max_level = max_level_r;
`endif

  // Head entry presented FWFT; zeroed while empty.
  always_comb begin
    if (level_r != {LW{1'b0}}) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = {(D + 1){1'b0}};
    end
  end

  assign m_axis_tvalid = (level_r != {LW{1'b0}});
  assign m_axis_tdata  = head_s[D-1:0];
  assign m_axis_tlast  = head_s[D];
  assign overflow      = ovf_r;
  assign level         = level_r;

endmodule

// File: tb/tb_ccsds123_res_axis_out.sv
// Self-checking bench for ccsds123_res_axis_out: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ccsds123_res_axis_out;

  localparam int D     = 16;
  localparam int DEPTH = 16;
  localparam int TOTAL = 256;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [D-1:0]  res = '0;
  logic          res_valid = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [D-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          overflow;
  logic [LW-1:0] level;
`ifdef CCSDS123_RES_AXIS_OUT_HWM_EN
  logic [LW-1:0] max_level;
`endif

  ccsds123_res_axis_out #(.D(D), .NX(4), .NY(4), .NZ(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .aresetn(aresetn), .res(res), .res_valid(res_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .overflow(overflow), .level(level)
`ifdef CCSDS123_RES_AXIS_OUT_HWM_EN
    , .max_level(max_level)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: a plain queue of {last,data}, image index, sticky flag
  logic [D:0] mq[$];
  int         mcnt = 0;
  bit         movf = 1'b0;
  logic [D:0] outq[$];
  int         exp_q[$];
  int         max_lvl_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mcnt = 0;
    movf = 1'b0;
  endtask

  task automatic model_step(input bit v, input int d, input bit rdy);
    bit pop;
    bit full;
    logic lst;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (v) begin
      lst = (mcnt == TOTAL - 1);
      if (!full || pop) mq.push_back({lst, d[D-1:0]});
      else movf = 1'b1;
      mcnt = (mcnt == TOTAL - 1) ? 0 : mcnt + 1;
    end
  endtask

  task automatic cycle(input bit v, input int d, input bit rdy);
    res_valid     = v;
    res           = d[D-1:0];
    m_axis_tready = rdy;
    @(posedge clk);
    #1;
    model_step(v, d, rdy);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mq.size() != 0 && guard < 200) begin
      cycle(1'b0, 0, 1'b1);
      guard++;
    end
    chk("drain_timeout", (guard < 200), 1);
    cycle(1'b0, 0, 1'b0);
  endtask

  // called half a cycle after an edge, away from any clock edge
  task automatic pulse_reset();
    res_valid     = 1'b0;
    m_axis_tready = 1'b0;
    #3;
    aresetn = 1'b0;
    model_clear();
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    repeat (2) @(posedge clk);
    #2;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    outq.delete();
    exp_q.delete();
    max_lvl_seen = 0;
  endtask

  task automatic check_out(input string nm);
    chk({nm, "_count"}, outq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
      chk({nm, "_data"}, outq[i][D-1:0], exp_q[i]);
      chk({nm, "_last"}, outq[i][D], ((exp_q[i] % TOTAL) == TOTAL - 1));
    end
  endtask

  // compare DUT against model every cycle; also log accepted beats and AXI hold
  initial begin : compare
    bit         prev_hold = 1'b0;
    logic [D:0] prev_beat = '0;
    forever begin
      @(negedge clk);
      chk("tvalid", m_axis_tvalid, (mq.size() != 0));
      chk("level", level, mq.size());
      chk("overflow", overflow, movf);
      if (mq.size() != 0) begin
        chk("tdata", m_axis_tdata, mq[0][D-1:0]);
        chk("tlast", m_axis_tlast, mq[0][D]);
      end
      if (!aresetn) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("axi_hold_valid", m_axis_tvalid, 1);
          chk("axi_hold_beat", {m_axis_tlast, m_axis_tdata}, prev_beat);
        end
        prev_hold = m_axis_tvalid && !m_axis_tready;
        prev_beat = {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) outq.push_back({m_axis_tlast, m_axis_tdata});
      end
      if (int'(level) > max_lvl_seen) max_lvl_seen = int'(level);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    int cyc;
    #1;
    chk("init_tvalid", m_axis_tvalid, 0);
    chk("init_level", level, 0);
    chk("init_overflow", overflow, 0);
    chk("init_tdata", m_axis_tdata, 0);
    #21;
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: pass-through
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, i, 1'b1);
      exp_q.push_back(i);
    end
    drain();
    check_out("t1");
    chk("t1_overflow", overflow, 0);
    chk("t1_maxlvl_le1", (max_lvl_seen <= 1), 1);

    // 2: bubbles on both sides
    pulse_reset();
    k = 0;
    cyc = 0;
    while (k < 256 && cyc < 2000) begin
      if (cyc % 3 == 0) begin
        cycle(1'b1, k, ((cyc * 5) % 4) < 2);
        exp_q.push_back(k);
        k++;
      end else begin
        cycle(1'b0, 0, ((cyc * 5) % 4) < 2);
      end
      cyc++;
    end
    drain();
    check_out("t2");

    // 3: full with simultaneous pop
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, i, 1'b0);
      exp_q.push_back(i);
    end
    chk("t3_full_level", level, 16);
    cycle(1'b1, 16, 1'b1);
    exp_q.push_back(16);
    chk("t3_level_stays", level, 16);
    chk("t3_no_overflow", overflow, 0);
    drain();
    check_out("t3");

    // 4: overflow, then framing still aligned
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, i, 1'b0);
      if (i < 16) exp_q.push_back(i);
      if (i == 15) chk("t4_ovf_after16", overflow, 0);
      if (i == 16) chk("t4_ovf_after17", overflow, 1);
    end
    chk("t4_level", level, 16);
    drain();
    for (int i = 20; i < 256; i++) begin
      cycle(1'b1, i, 1'b1);
      exp_q.push_back(i);
    end
    drain();
    check_out("t4");
    chk("t4_ovf_sticky", overflow, 1);

    // 5: two images
    pulse_reset();
    for (int i = 0; i < 512; i++) begin
      cycle(1'b1, i, 1'b1);
      exp_q.push_back(i);
    end
    drain();
    check_out("t5");

    // 6: reset mid-stream
    pulse_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, i, 1'b0);
    chk("t6_level_full", level, 16);
    chk("t6_overflow", overflow, 1);
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, i, 1'b1);
      exp_q.push_back(i);
    end
    drain();
    check_out("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccsds123_res_axis_out.md
Name: ccsds123_res_axis_out

Overview:
Output-side adapter for the CCSDS-123 compressor core. It takes the core's non-stallable mapped-residual stream (res/res_valid) and presents it as an AXI4-Stream master with backpressure. Buffering is an internal FIFO. The block generates tlast on the final residual of each NX*NY*NZ image and flags any residual lost to overflow. It sits directly after ccsds123_top, ahead of the entropy coder or DMA.

Parameters:
D, 16, residual width in bits
NX, 4, image width in samples
NY, 4, image height in samples
NZ, 16, number of spectral bands
DEPTH, 16, FIFO depth in entries; power of two, >= 2

Ports:
clk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
res  in  D  mapped residual from compressor core
res_valid  in  1  res valid this cycle; no ready, cannot be stalled
m_axis_tdata  out  D  residual to downstream
m_axis_tvalid  out  1  m_axis_tdata/tlast valid
m_axis_tready  in  1  downstream accepts
m_axis_tlast  out  1  high with last residual of an image
overflow  out  1  sticky: a residual was dropped
level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (aresetn low, asynchronous): FIFO empty, level=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, sample counter=0. Mid-stream reset discards buffered data. The next accepted residual is sample 0 of a new image.
- FIFO storage: {last, res}, D+1 bits per entry. Read and write pointers wrap modulo DEPTH. Full when level==DEPTH, empty when level==0.
- Pop: occurs when m_axis_tvalid && m_axis_tready.
- Push: occurs when res_valid && (level<DEPTH || pop this cycle). Full plus simultaneous pop therefore accepts the write, and level stays at DEPTH.
- Drop: res_valid && level==DEPTH && !pop. The residual is discarded, overflow is set and held until reset, and the sample counter still advances so image framing stays aligned.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Sample counter: counts pushes and drops from 0 to NX*NY*NZ-1. The last bit is set on the entry where counter==NX*NY*NZ-1. The counter then wraps to 0.
- Output is first-word fall-through. m_axis_tvalid=(level!=0), with tdata/tlast from the head entry.
- Latency: a residual pushed at edge N into an empty FIFO appears on m_axis_* after edge N, and is poppable at edge N+1.
- AXI rules: once tvalid is high, tdata, tlast and tvalid hold until the pop. tvalid never depends combinationally on tready.
- Pop from empty and push to full without pop are impossible by construction. No X on outputs after reset.

Optional Feature:
Macro CCSDS123_RES_AXIS_OUT_HWM_EN.
- Defined: adds output port max_level (same width as level), a high-water mark. It resets to 0 and updates each cycle to max(max_level, next level). It is also used for sizing DEPTH in simulation.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
1. Basic pass-through: NX=NY=4, NZ=16, res=0..255 one per cycle, tready=1 -> m_axis_tdata 0..255 in order; tlast only on 255; overflow=0; max level <=1.
2. Random bubbles on both sides: res_valid 1/3 duty, tready 1/2 duty -> 256 outputs equal 0..255 in order. AXI stability checked every cycle tvalid&&!tready.
3. Full with simultaneous pop: DEPTH=16, tready=0 for 16 pushes (level=16), then tready=1 and res_valid=1 same cycle -> push accepted, level stays 16, overflow=0.
4. Overflow: tready=0, push 20 residuals 0..19 -> level=16, overflow=1 from the 17th push onward. After tready=1, outputs are 0..15 only. A full image of 256 still ends with tlast on value 255 of the next image boundary (counter alignment).
5. Multi-image wrap: 512 residuals, tready=1 -> tlast on outputs 255 and 511 only.
6. Reset mid-stream: after 100 residuals with tready=0 and level=16, pulse aresetn low asynchronously -> outputs immediately tvalid=0, level=0, overflow=0. Then 256 new residuals give tlast on the 256th.
